shift_deserializer: RTL and testbench

Serial-to-parallel receiver forming the far end of the shift-register link. It accepts one bit per qualified clock, assembles WIDTH-bit words MSB-first or LSB-first, and presents each completed word on a registered parallel output with a valid/ready handshake. A sticky overrun flag reports words dropped because the consumer stalled.

---
 rtl/shift_deserializer.sv | 111 +++++++++++
 tb/tb_shift_deserializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_deserializer.sv
// shift_deserializer
//   Serial-to-parallel receiver. Accepts one bit per clock on which bit_valid
//   is high and assembles WIDTH-bit words, either MSB-first or LSB-first. Each
//   completed word is presented on a registered output with a valid/ready
//   handshake. A sticky flag reports words that were dropped because the
//   consumer stalled.
//
// Ports
//   clk              : rising-edge clock
//   reset            : asynchronous reset, active low
//   serial_in        : incoming data bit
//   bit_valid        : serial_in is accepted on this edge
//   left_right_shift : 0 = MSB-first (left shift), 1 = LSB-first (right shift);
//                      sampled only on the first bit of each word
//   clear            : synchronous flush of the partial word and of overrun
//   q                : last completed word
//   q_valid          : q holds an unconsumed word
//   q_ready          : consumer takes q on an edge where q_valid is high
//   overrun          : sticky, a completed word was dropped
//   bit_count        : number of bits in the current partial word
module shift_deserializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     serial_in,
  input  logic                     bit_valid,
  input  logic                     left_right_shift,
  input  logic                     clear,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  input  logic                     q_ready,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t           r_state;
  logic             r_dir;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;
  logic             r_overrun;
  logic [CW-1:0]    r_count;

  logic             w_dir;
  logic [WIDTH-1:0] w_sr_next;
  logic             w_last;

  // The first bit of a word uses the live direction input; later bits use the
  // direction latched with that first bit.
  always_comb begin
    w_dir     = (r_state == IDLE) ? left_right_shift : r_dir;
    w_sr_next = w_dir ? {serial_in, r_sr[WIDTH-1:1]}
                      : {r_sr[WIDTH-2:0], serial_in};
    w_last    = (r_state == COLLECT) && (r_count == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_dir     <= 1'b0;
      r_sr      <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_overrun <= 1'b0;
      r_count   <= '0;
    end else begin
      // Consumer handshake; a completion on the same edge overrides below.
      if (r_q_valid && q_ready)
        r_q_valid <= 1'b0;

      if (clear) begin
        r_state   <= IDLE;
        r_sr      <= '0;
        r_count   <= '0;
        r_overrun <= 1'b0;
      end else if (bit_valid) begin
        r_sr <= w_sr_next;
        if (r_state == IDLE)
          r_dir <= left_right_shift;

        if (w_last) begin
          r_state <= IDLE;
          r_count <= '0;
          if (!r_q_valid || q_ready) begin
            r_q       <= w_sr_next;
            r_q_valid <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
        end else begin
          r_state <= COLLECT;
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign q         = r_q;
  assign q_valid   = r_q_valid;
  assign overrun   = r_overrun;
  assign bit_count = r_count;

endmodule

// File: tb/tb_shift_deserializer.sv
module tb_shift_deserializer;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W);

  logic          clk;
  logic          reset;
  logic          serial_in;
  logic          bit_valid;
  logic          left_right_shift;
  logic          clear;
  logic [W-1:0]  q;
  logic          q_valid;
  logic          q_ready;
  logic          overrun;
  logic [CW-1:0] bit_count;

  int checks = 0;
  int errors = 0;

  shift_deserializer #(.WIDTH(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .serial_in        (serial_in),
    .bit_valid        (bit_valid),
    .left_right_shift (left_right_shift),
    .clear            (clear),
    .q                (q),
    .q_valid          (q_valid),
    .q_ready          (q_ready),
    .overrun          (overrun),
    .bit_count        (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: received bits of the partial word kept in a queue;
  // the word is assembled only when WIDTH bits have arrived.
  bit           m_bits[$];
  bit           m_dir;
  logic [W-1:0] m_q;
  logic         m_qv;
  logic         m_ovr;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_bits.delete();
      m_dir = 1'b0;
      m_q   = '0;
      m_qv  = 1'b0;
      m_ovr = 1'b0;
    end else begin
      logic         hs;
      logic         done;
      logic [W-1:0] word;
      hs   = m_qv && q_ready;
      done = 1'b0;
      if (clear) begin
        m_bits.delete();
        m_ovr = 1'b0;
      end else if (bit_valid) begin
        if (m_bits.size() == 0) m_dir = left_right_shift;
        m_bits.push_back(serial_in);
        if (m_bits.size() == W) begin
          word = '0;
          for (int i = 0; i < W; i++) begin
            if (m_dir) word[i]       = m_bits[i];
            else       word[W-1-i]   = m_bits[i];
          end
          done = 1'b1;
          if (!m_qv || q_ready) begin
            m_q  = word;
            m_qv = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
          m_bits.delete();
        end
      end
      if (hs && !done) m_qv = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("q", 32'(q), 32'(m_q));
    chk("q_valid", 32'(q_valid), 32'(m_qv));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("bit_count", 32'(bit_count), 32'(m_bits.size()));
  end

  task automatic drive(input logic v, input logic b, input logic d,
                       input logic r, input logic c);
    @(negedge clk);
    bit_valid        = v;
    serial_in        = b;
    left_right_shift = d;
    q_ready          = r;
    clear            = c;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] word, input logic dir,
                           input logic rdy, input logic rdy_last,
                           input logic toggle);
    for (int i = 0; i < W; i++) begin
      logic b;
      logic d;
      b = dir ? word[i] : word[W-1-i];
      d = (toggle && i >= 3) ? ~dir : dir;
      drive(1'b1, b, d, (i == W-1) ? rdy_last : rdy, 1'b0);
    end
  endtask

  initial begin
    logic [W-1:0] pat;
    reset            = 1'b0;
    serial_in        = 1'b0;
    bit_valid        = 1'b0;
    left_right_shift = 1'b0;
    clear            = 1'b0;
    q_ready          = 1'b0;
    #12;
    chk("reset_q", 32'(q), 32'h0);
    chk("reset_qv", 32'(q_valid), 32'h0);
    chk("reset_bc", 32'(bit_count), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // MSB-first, bit_count stepping
    pat = 8'b1011_0011;
    for (int i = 0; i < W; i++) begin
      drive(1'b1, pat[W-1-i], 1'b0, 1'b1, 1'b0);
      after_edge();
      chk("t1_bc", 32'(bit_count), 32'((i + 1) % W));
    end
    chk("t1_q", 32'(q), 32'hB3);
    chk("t1_qv", 32'(q_valid), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("t1_qv_drop", 32'(q_valid), 32'h0);

    // LSB-first with direction toggled mid-word
    send_word(8'hCD, 1'b1, 1'b1, 1'b1, 1'b1);
    after_edge();
    chk("t2_q", 32'(q), 32'hCD);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Sparse bit_valid
    pat = 8'hA5;
    for (int i = 0; i < W; i++) begin
      drive(1'b1, pat[W-1-i], 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      after_edge();
      chk("t3_bc_hold", 32'(bit_count), 32'((i + 1) % W));
    end
    chk("t3_q", 32'(q), 32'hA5);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Stalled consumer, overrun, then clear
    send_word(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("t4_q", 32'(q), 32'h3C);
    chk("t4_qv", 32'(q_valid), 32'h1);
    chk("t4_ovr", 32'(overrun), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    after_edge();
    chk("t4_ovr_clr", 32'(overrun), 32'h0);
    chk("t4_q_hold", 32'(q), 32'h3C);
    chk("t4_qv_hold", 32'(q_valid), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Ready on the exact completion edge of the second word
    send_word(8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'h34, 1'b0, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("t5_q", 32'(q), 32'h34);
    chk("t5_qv", 32'(q_valid), 32'h1);
    chk("t5_ovr", 32'(overrun), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-word
    pat = 8'h5F;
    for (int i = 0; i < 5; i++)
      drive(1'b1, pat[W-1-i], 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bit_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_q", 32'(q), 32'h0);
    chk("t6_rst_qv", 32'(q_valid), 32'h0);
    chk("t6_rst_ovr", 32'(overrun), 32'h0);
    chk("t6_rst_bc", 32'(bit_count), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    send_word(8'h81, 1'b0, 1'b1, 1'b1, 1'b0);
    after_edge();
    chk("t6_q", 32'(q), 32'h81);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 799) == 0) begin
        @(negedge clk);
        bit_valid = 1'b0;
        #3 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
